seq_mult32_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 18 +
 rtl/seq_mult32_ctrl_if.sv | 15 +
 rtl/pp_mult8.sv | 12 +
 rtl/seq_mult32_ctrl.sv | 95 +++++++++
 tb/tb_seq_mult32_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizes for the sequential 32x32 multiplier and its 8x8 core.
package mult_pkg;

    localparam int unsigned OPW   = 32;
    localparam int unsigned SLW   = 8;
    localparam int unsigned PPW   = 2 * SLW;
    localparam int unsigned NSTEP = 16;
    localparam int unsigned KW    = 4;
    localparam int unsigned PW    = 64;
    localparam int unsigned SHW   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult32_ctrl_if.sv
// Request/response bundle between a requester and the sequential multiplier.
interface seq_mult32_ctrl_if;
    import mult_pkg::*;

    logic           start;
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           busy;
    logic           done;
    logic [PW-1:0]  product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/pp_mult8.sv
// Combinational 8x8 -> 16-bit unsigned partial-product core; swappable for any library core.
module pp_mult8
    import mult_pkg::*;
(
    input  logic [SLW-1:0] x,
    input  logic [SLW-1:0] y,
    output logic [PPW-1:0] p_c
);

    assign p_c = PPW'(x) * PPW'(y);

endmodule

// File: rtl/seq_mult32_ctrl.sv
// Sequential 32x32 multiplier: one 8x8 core time-shared over 16 steps into a 64-bit accumulator.
module seq_mult32_ctrl
    import mult_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    seq_mult32_ctrl_if.slave    bus
);

    state_e         state_q, state_d;
    logic [OPW-1:0] ra_q, ra_d;
    logic [OPW-1:0] rb_q, rb_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [KW-1:0]  k_q, k_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [1:0]     i_c, j_c;
    logic [SLW-1:0] a_sl_c, b_sl_c;
    logic [PPW-1:0] pp_c;
    logic [SHW-1:0] sh_c;
    logic [PW-1:0]  addend_c;

    // Step k walks the multiplicand slice fastest, then the multiplier slice.
    always_comb begin
        i_c      = k_q[1:0];
        j_c      = k_q[3:2];
        a_sl_c   = ra_q[32'(i_c) * SLW +: SLW];
        b_sl_c   = rb_q[32'(j_c) * SLW +: SLW];
        sh_c     = SHW'((32'(i_c) + 32'(j_c)) * SLW);
        addend_c = PW'(pp_c) << sh_c;
    end

    pp_mult8 u_pp (
        .x   (a_sl_c),
        .y   (b_sl_c),
        .p_c (pp_c)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        acc_d   = acc_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ((bus.a == '0) || (bus.b == '0)) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = acc_q + addend_c;
                k_d   = k_q + KW'(1);
                if (k_q == KW'(NSTEP - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Status flags follow the next state so they are flops, not input decodes.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = acc_q;

endmodule

// File: tb/tb_seq_mult32_ctrl.sv
// Directed and random checks for seq_mult32_ctrl: latency, busy length, products, reset abort.
module tb_seq_mult32_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_mult32_ctrl_if mif ();

    seq_mult32_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
        int          lat;
        int          bcnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Launch one op and observe it for 40 cycles; lat counts edges after the accept edge.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                          output logic [63:0] p, output int lat, output int bcnt, output int dcnt);
        bit seen;
        @(negedge clk);
        mif.start = 1'b1;
        mif.a     = ta;
        mif.b     = tb_;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        seen = 1'b0;
        lat  = -1;
        bcnt = 0;
        dcnt = 0;
        p    = '0;
        for (int c = 0; c < 40; c++) begin
            mif.a = $urandom;
            if (mif.busy) bcnt++;
            if (mif.done) begin
                dcnt++;
                if (!seen) begin
                    seen = 1'b1;
                    lat  = c;
                    p    = mif.product;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic fast_op(input logic [31:0] ta, input logic [31:0] tb_);
        bit seen;
        @(negedge clk);
        mif.start = 1'b1;
        mif.a     = ta;
        mif.b     = tb_;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (mif.done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rand_done_seen", 64'(seen), 64'd1);
        chk("rand_product", mif.product, 64'(ta) * 64'(tb_));
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] p;
        int          lat, bcnt, dcnt;
        logic [31:0] ra, rb;

        checks = 0;
        errors = 0;

        vecs[0] = '{32'd3,        32'd5,        64'h0000_0000_0000_000F, 16, 17};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 16, 17};
        vecs[2] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 16, 17};
        vecs[3] = '{32'd0,        32'hDEAD_BEEF, 64'h0,                  0,  1};
        vecs[4] = '{32'hDEAD_BEEF, 32'd0,        64'h0,                  0,  1};
        vecs[5] = '{32'd1,        32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 16, 17};
        vecs[6] = '{32'h8000_0000, 32'd2,        64'h0000_0001_0000_0000, 16, 17};
        vecs[7] = '{32'h0000_00FF, 32'h0000_00FF, 64'h0000_0000_0000_FE01, 16, 17};
        vecs[8] = '{32'h0100_0000, 32'h0100_0000, 64'h0001_0000_0000_0000, 16, 17};

        rst       = 1'b1;
        mif.start = 1'b0;
        mif.a     = '0;
        mif.b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(mif.busy), 64'd0);
        chk("reset_done", 64'(mif.done), 64'd0);
        chk("reset_product", mif.product, 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].a, vecs[v].b, p, lat, bcnt, dcnt);
            chk($sformatf("v%0d_product", v), p, vecs[v].p);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
            chk($sformatf("v%0d_busy_cycles", v), 64'(bcnt), 64'(vecs[v].bcnt));
            chk($sformatf("v%0d_done_pulses", v), 64'(dcnt), 64'd1);
            chk($sformatf("v%0d_hold", v), mif.product, vecs[v].p);
        end

        // Start re-asserted with new operands during CALC must be ignored.
        @(negedge clk);
        mif.start = 1'b1;
        mif.a     = 32'd7;
        mif.b     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        lat = -1; bcnt = 0; dcnt = 0; p = '0;
        for (int c = 0; c < 40; c++) begin
            if (mif.busy) bcnt++;
            if (mif.done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = c;
                    p   = mif.product;
                end
            end
            if (c >= 5 && c < 12) begin
                mif.start = 1'b1;
                mif.a     = (c == 5) ? 32'hFFFF_FFFF : $urandom;
                mif.b     = 32'hFFFF_FFFF;
            end else begin
                mif.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("repulse_product", p, 64'h3F);
        chk("repulse_latency", 64'(lat), 64'd16);
        chk("repulse_busy_cycles", 64'(bcnt), 64'd17);
        chk("repulse_done_pulses", 64'(dcnt), 64'd1);

        // Reset in the middle of a long op abandons it with no done pulse.
        @(negedge clk);
        mif.start = 1'b1;
        mif.a     = 32'h1234_5678;
        mif.b     = 32'h9ABC_DEF0;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_busy", 64'(mif.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_product", mif.product, 64'd0);
        chk("midrst_busy", 64'(mif.busy), 64'd0);
        chk("midrst_done", 64'(mif.done), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (mif.done) dcnt++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);

        run_op(32'd3, 32'd5, p, lat, bcnt, dcnt);
        chk("post_rst_product", p, 64'hF);
        chk("post_rst_latency", 64'(lat), 64'd16);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 50 == 7) ra = 32'd0;
            fast_op(ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
